byte_rx_buffer: RTL and testbench
=================================

# byte_rx_buffer

Downstream stage of the serial-to-parallel deserializer: captures each completed byte (`data_ready`/`data_out`), returns the one-cycle `ack_in` pulse that frees the deserializer, and queues the bytes in a DEPTH-entry FIFO. Consumers read the FIFO through a show-ahead read port. Single clock domain (`clk_100mhz`), shared `reset` with the deserializer.

## Interface

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), pointer width

Ports:
- clk_100mhz  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- byte_in  in  8  deserializer `data_out`
- byte_ready  in  1  deserializer `data_ready`; held high until acknowledged
- ack_out  out  1  to deserializer `ack_in`; one-cycle registered pulse
- read_in  in  1  consumer pop request
- data_out  out  8  FIFO head; 8'h00 when empty
- data_valid  out  1  FIFO non-empty
- count_out  out  ADDR_W+1  current occupancy, 0..DEPTH
- full_out  out  1  count_out == DEPTH
- underflow_err  out  1  sticky; set by `read_in` while empty

## Operation

- Capture FSM states:
  - **IDLE**
    - Sampled `byte_ready`=1 and `full_out`=0: write `byte_in` at `wr_ptr`, increment `wr_ptr`, set `ack_out`<=1, go to **ACK**.
    - Sampled `byte_ready`=1 and `full_out`=1: stay in IDLE with no ack. The deserializer stalls, holding its byte.
  - **ACK**
    - `ack_out`=1 for exactly this cycle. Next edge: `ack_out`<=0, go to **WAIT_LOW**.
  - **WAIT_LOW**
    - Stay until sampled `byte_ready`=0, then go to IDLE. This guarantees no double capture while the deserializer's `data_ready` is still falling.
- Read side:
  - `read_in`=1 with `data_valid`=1: increment `rd_ptr`.
  - `read_in`=1 with `data_valid`=0: ignored, except that it sets `underflow_err`.
- Simultaneous write and pop in the same cycle: both take effect; count is unchanged.
  - `full_out` is evaluated from the registered count, so no write is accepted when full, even with a concurrent pop.
- Pointers are ADDR_W bits and wrap naturally. Count is a separate ADDR_W+1-bit register: +1 on write only, −1 on pop only.
- `data_out` = `mem[rd_ptr]` when `data_valid`, else 8'h00 (combinational from registered state).
- FIFO storage is not reset; only pointers, count, FSM and flags are reset.

## Timing

- Reset values: FSM=IDLE, `ack_out`=0, `count_out`=0, `data_valid`=0, `full_out`=0, `data_out`=8'h00, `underflow_err`=0, both pointers 0.
- Reset asserted mid-handshake (ACK or WAIT_LOW): return to IDLE next edge with `ack_out`=0. A byte already written is discarded with the pointers.
- Capture timeline:

  | Cycle | Event |
  |---|---|
  | N | `byte_ready` sampled high in IDLE |
  | N+1 | `ack_out`=1; byte visible on `data_out` if FIFO was empty; `count_out` incremented |
  | N+2 | deserializer drops `data_ready` |
  | N+3 | FSM back in IDLE |

- Minimum 3 cycles per byte. This is non-limiting, since the deserializer needs ≥ 8 write cycles per byte.
- Pop: `data_out`/`count_out` update on the edge after `read_in`.
- `underflow_err` sets on the edge after the offending read and holds until reset.

## Test plan

- Reset then idle → all outputs at reset values; `ack_out` never pulses with `byte_ready`=0.
- Single byte 8'hA5 with `byte_ready` held high until 1 cycle after ack → exactly one `ack_out` pulse, 1 cycle wide, at N+1; `data_out`=8'hA5, `count_out`=1; no second write while in WAIT_LOW.
- Push 8 bytes 8'h01..8'h08 with no reads (DEPTH=8) → `full_out`=1, `count_out`=8. A ninth byte 8'hFF holds `byte_ready` high with no ack. One pop returns 8'h01; 8'hFF is then acked and stored; pop order continues 8'h02..8'h08, 8'hFF.
- Wrap-around: 20 bytes with interleaved single pops, occupancy kept between 1 and 3 → output sequence identical to input; pointers wrap with no loss.
- Simultaneous capture and pop at `count_out`=2 → `count_out` stays 2; head advances; new byte appended at tail.
- `read_in` pulse while empty → `underflow_err`=1 next cycle and sticky; `count_out` stays 0. Reset asserted during ACK state → `ack_out`=0, `count_out`=0, `underflow_err`=0 on the following edge.

Source files
------------

// File: rtl/byte_rx_buffer.sv
// byte_rx_buffer: captures bytes from the deserializer with a three-state
// ready/ack handshake and queues them in a DEPTH-entry show-ahead FIFO.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for byte_ready; captures when the FIFO is not full
// ACK      | ack_out high for exactly this cycle; byte already written
// WAIT_LOW | waiting for byte_ready to fall so a byte is never taken twice
module byte_rx_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_ready,
  output logic              ack_out,
  input  logic              read_in,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic [ADDR_W:0]   count_out,
  output logic              full_out,
  output logic              underflow_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_en;
  logic              pop;

  // Full is taken from the registered count, so a concurrent pop never
  // opens a slot for a write in the same cycle.
  assign full_out   = (count_out == FULL_CNT);
  assign data_valid = (count_out != '0);
  assign wr_en      = (state == IDLE) && byte_ready && !full_out;
  assign pop        = read_in && data_valid;
  assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;

  // Capture handshake FSM with registered ack pulse.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state   <= IDLE;
      ack_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (byte_ready && !full_out) begin
            state   <= ACK;
            ack_out <= 1'b1;
          end
        end
        ACK: begin
          state   <= WAIT_LOW;
          ack_out <= 1'b0;
        end
        WAIT_LOW: begin
          ack_out <= 1'b0;
          if (!byte_ready) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ack_out <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage write; contents are deliberately not reset.
  always_ff @(posedge clk_100mhz) begin
    if (wr_en) mem[wr_ptr] <= byte_in;
  end

  // Pointers, occupancy count and sticky underflow flag.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_out     <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count_out <= count_out + CNT_ONE;
        2'b01:   count_out <= count_out - CNT_ONE;
        default: count_out <= count_out;
      endcase
      if (read_in && !data_valid) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_rx_buffer.sv
// Directed self-checking bench for byte_rx_buffer (DEPTH = 8).
module tb_byte_rx_buffer;

  logic       clk_100mhz = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_ready;
  logic       ack_out;
  logic       read_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] count_out;
  logic       full_out;
  logic       underflow_err;

  int n_assert = 0;
  int n_fail   = 0;

  byte_rx_buffer #(.DEPTH(8)) dut (
    .clk_100mhz    (clk_100mhz),
    .reset         (reset),
    .byte_in       (byte_in),
    .byte_ready    (byte_ready),
    .ack_out       (ack_out),
    .read_in       (read_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .count_out     (count_out),
    .full_out      (full_out),
    .underflow_err (underflow_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte, wait (bounded) for the ack, check its width, finish handshake.
  task automatic push(input logic [7:0] b);
    bit got;
    got = 1'b0;
    byte_in    = b;
    byte_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ack_out) got = 1'b1;
    end
    chk("push_ack_seen", got, 1'b1);
    tick();
    chk("push_ack_width", ack_out, 1'b0);
    byte_ready = 1'b0;
    tick();
  endtask

  // Check the show-ahead head, then pop it.
  task automatic pop(input logic [7:0] exp);
    chk("pop_valid", data_valid, 1'b1);
    chk("pop_data", data_out, exp);
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
  endtask

  initial begin
    logic [3:0] c;
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_ready = 1'b0;
    read_in    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    chk("rst_ack", ack_out, 1'b0);
    chk("rst_count", count_out, 4'd0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_full", full_out, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_uflow", underflow_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_no_ack", ack_out, 1'b0);
    end

    // Single byte A5, ready held through an extra WAIT_LOW cycle
    byte_in    = 8'hA5;
    byte_ready = 1'b1;
    tick();
    chk("single_ack_n1", ack_out, 1'b1);
    chk("single_data", data_out, 8'hA5);
    chk("single_count", count_out, 4'd1);
    tick();
    chk("single_ack_drop", ack_out, 1'b0);
    tick();
    chk("single_no_rewrite", count_out, 4'd1);
    chk("single_no_ack2", ack_out, 1'b0);
    byte_ready = 1'b0;
    tick();
    tick();
    chk("single_count_final", count_out, 4'd1);
    pop(8'hA5);
    chk("single_empty_count", count_out, 4'd0);
    chk("single_empty_data", data_out, 8'h00);

    // Fill to DEPTH, ninth byte stalls until a pop frees a slot
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("fill_full", full_out, 1'b1);
    chk("fill_count", count_out, 4'd8);
    byte_in    = 8'hFF;
    byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_no_ack", ack_out, 1'b0);
    end
    chk("full_count_hold", count_out, 4'd8);
    chk("full_head", data_out, 8'h01);
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    chk("full_pop_no_write", count_out, 4'd7);
    chk("full_pop_no_ack", ack_out, 1'b0);
    tick();
    chk("ninth_ack", ack_out, 1'b1);
    chk("ninth_count", count_out, 4'd8);
    tick();
    byte_ready = 1'b0;
    tick();
    for (int i = 2; i <= 8; i++) pop(8'(i));
    pop(8'hFF);
    chk("drain_count", count_out, 4'd0);

    // Wrap-around: 20 bytes, occupancy alternating 1 and 2
    push(8'h30);
    for (int i = 1; i < 20; i++) begin
      push(8'(8'h30 + i));
      chk("wrap_count2", count_out, 4'd2);
      pop(8'(8'h30 + i - 1));
    end
    pop(8'h43);
    chk("wrap_empty", count_out, 4'd0);

    // Simultaneous capture and pop at count 2
    push(8'hC1);
    push(8'hC2);
    c = count_out;
    chk("sim_pre_count", c, 4'd2);
    byte_in    = 8'hC3;
    byte_ready = 1'b1;
    read_in    = 1'b1;
    tick();
    read_in = 1'b0;
    chk("sim_ack", ack_out, 1'b1);
    chk("sim_count", count_out, 4'd2);
    chk("sim_head", data_out, 8'hC2);
    tick();
    byte_ready = 1'b0;
    tick();
    pop(8'hC2);
    pop(8'hC3);
    chk("sim_empty", count_out, 4'd0);

    // Underflow: sticky, count unchanged
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    chk("uflow_set", underflow_err, 1'b1);
    chk("uflow_count", count_out, 4'd0);
    tick();
    tick();
    chk("uflow_sticky", underflow_err, 1'b1);

    // Reset during ACK
    byte_in    = 8'h55;
    byte_ready = 1'b1;
    tick();
    chk("mid_ack", ack_out, 1'b1);
    chk("mid_count", count_out, 4'd1);
    reset      = 1'b1;
    byte_ready = 1'b0;
    tick();
    chk("mid_rst_ack", ack_out, 1'b0);
    chk("mid_rst_count", count_out, 4'd0);
    chk("mid_rst_uflow", underflow_err, 1'b0);
    chk("mid_rst_valid", data_valid, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_ack", ack_out, 1'b0);
    chk("post_rst_data", data_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
